// File: rtl/peridot_phy_txarb_if.sv
// rtl/peridot_phy_txarb_if.sv - requester and TX phy handshake bundle for the UART TX arbiter
interface peridot_phy_txarb_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]   in_valid;
    logic [8*NUM_PORTS-1:0] in_data;
    logic [NUM_PORTS-1:0]   in_startofpacket;
    logic [NUM_PORTS-1:0]   in_endofpacket;
    logic [NUM_PORTS-1:0]   in_ready;
    logic                   out_ready;
    logic                   out_valid;
    logic [7:0]             out_data;
    logic [1:0]             out_channel;

    // Sources and the TX phy side.
    modport master (
        output in_valid,
        output in_data,
        output in_startofpacket,
        output in_endofpacket,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_channel
    );

    // The arbiter itself.
    modport slave (
        input  in_valid,
        input  in_data,
        input  in_startofpacket,
        input  in_endofpacket,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_channel
    );
endinterface

// File: rtl/peridot_phy_txarb.sv
// rtl/peridot_phy_txarb.sv - round-robin UART TX byte arbiter with channel headers and byte escaping
module peridot_phy_txarb #(
    parameter int NUM_PORTS   = 2,
    parameter bit LOCK_PACKET = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    peridot_phy_txarb_if.slave  bus
);
    localparam logic [7:0] CH_BYTE  = 8'h7C;
    localparam logic [7:0] ESC_BYTE = 8'h7D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHNUM = 2'd1,
        ST_DATA  = 2'd2,
        ST_ESC   = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] grant;
    logic [1:0] last_grant;
    logic       out_valid_q;
    logic [7:0] out_data_q;
    logic [1:0] out_channel_q;
    logic       ch_valid;
    logic [7:0] esc_reg;
    logic       eop_pend;

    // Pad the per-port vectors to four ports so a 2-bit grant indexes them exactly.
    logic [3:0]  valid_pad;
    logic [3:0]  eop_pad;
    logic [31:0] data_pad;
    logic [3:0]  ready_pad;

    assign valid_pad = 4'(bus.in_valid);
    assign eop_pad   = 4'(bus.in_endofpacket);
    assign data_pad  = 32'(bus.in_data);

    logic unused_sop;
    assign unused_sop = ^bus.in_startofpacket;

    logic       slot_free;
    logic       sel_valid;
    logic       sel_eop;
    logic [7:0] sel_data;
    logic       sel_reserved;
    logic       any_req;
    logic [1:0] arb_pick;
    logic       xfer;

    assign slot_free    = !out_valid_q || bus.out_ready;
    assign sel_valid    = valid_pad[grant];
    assign sel_eop      = eop_pad[grant];
    assign sel_data     = data_pad[{grant, 3'b000} +: 8];
    assign sel_reserved = (sel_data == CH_BYTE) || (sel_data == ESC_BYTE);
    assign any_req      = |valid_pad;
    assign xfer         = (state == ST_DATA) && sel_valid && slot_free;

    // First requester strictly after the previous winner, wrapping over the live ports.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
        logic [1:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last) + k) % NUM_PORTS;
            if (!found && req[2'(idx)]) begin
                found = 1'b1;
                pick  = 2'(idx);
            end
        end
        return pick;
    endfunction

    assign arb_pick = rr_pick(last_grant, valid_pad);

    always_comb begin
        ready_pad = 4'b0000;
        if (state == ST_DATA && slot_free) begin
            ready_pad = 4'b0001 << grant;
        end
    end

    assign bus.in_ready    = ready_pad[NUM_PORTS-1:0];
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_channel = out_channel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            grant         <= 2'd0;
            last_grant    <= 2'(NUM_PORTS - 1);
            out_valid_q   <= 1'b0;
            out_data_q    <= 8'h00;
            out_channel_q <= 2'd0;
            ch_valid      <= 1'b0;
            esc_reg       <= 8'h00;
            eop_pend      <= 1'b0;
        end else begin
            // The phy consumes the slot; any load below refills it in the same cycle.
            if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (any_req && slot_free) begin
                        grant <= arb_pick;
                        if (!ch_valid || arb_pick != out_channel_q) begin
                            out_data_q  <= CH_BYTE;
                            out_valid_q <= 1'b1;
                            state       <= ST_CHNUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end

                ST_CHNUM: begin
                    if (slot_free) begin
                        out_data_q    <= {6'b000000, grant};
                        out_valid_q   <= 1'b1;
                        out_channel_q <= grant;
                        ch_valid      <= 1'b1;
                        state         <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (xfer) begin
                        out_valid_q <= 1'b1;
                        if (sel_reserved) begin
                            out_data_q <= ESC_BYTE;
                            esc_reg    <= sel_data ^ 8'h20;
                            eop_pend   <= sel_eop;
                            state      <= ST_ESC;
                        end else begin
                            out_data_q <= sel_data;
                            if (sel_eop || !LOCK_PACKET) begin
                                last_grant <= grant;
                                state      <= ST_IDLE;
                            end
                        end
                    end
                end

                ST_ESC: begin
                    if (slot_free) begin
                        out_data_q  <= esc_reg;
                        out_valid_q <= 1'b1;
                        if (eop_pend || !LOCK_PACKET) begin
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_peridot_phy_txarb.sv
// tb/tb_peridot_phy_txarb.sv - directed self-checking bench for peridot_phy_txarb
module tb_peridot_phy_txarb;
    localparam int NP = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    peridot_phy_txarb_if #(.NUM_PORTS(NP)) bus ();

    peridot_phy_txarb #(
        .NUM_PORTS   (NP),
        .LOCK_PACKET (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    bit         ready_toggle = 1'b0;
    bit         mon_r1 = 1'b0;
    bit         saw_r1 = 1'b0;
    bit         hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;
    int         w0;
    int         w1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        check_val({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check_val($sformatf("%s_b%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
        end
        cap_q.delete();
    endtask

    task automatic send_pkt(input int p, input logic [31:0] word, input int n, output int first_wait);
        logic [31:0] w;
        int          waits;
        bit          ok;
        w          = word;
        ok         = 1'b1;
        first_wait = -1;
        @(posedge clk);
        #1;
        for (int i = 0; i < n && ok; i++) begin
            bus.in_data[8*p +: 8]      = w[8*i +: 8];
            bus.in_startofpacket[p]    = (i == 0);
            bus.in_endofpacket[p]      = (i == n - 1);
            bus.in_valid[p]            = 1'b1;
            waits = 0;
            forever begin
                @(negedge clk);
                if (bus.in_ready[p]) break;
                waits++;
                if (waits > 200) begin
                    check_val($sformatf("timeout_p%0d", p), 32'd0, 32'd1);
                    ok = 1'b0;
                    break;
                end
            end
            if (i == 0) first_wait = waits;
            if (ok) begin
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid[p]         = 1'b0;
        bus.in_startofpacket[p] = 1'b0;
        bus.in_endofpacket[p]   = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_toggle) bus.out_ready = ~bus.out_ready;
        end
    end

    // Capture accepted bytes and check the slot holds steady while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check_val("hold_valid", 32'(bus.out_valid), 32'd1);
                    check_val("hold_data", 32'(bus.out_data), 32'(hold_data));
                end
                if (bus.out_valid && bus.out_ready) cap_q.push_back(bus.out_data);
                if (mon_r1 && bus.in_ready[1]) saw_r1 = 1'b1;
                hold_pend = bus.out_valid && !bus.out_ready;
                hold_data = bus.out_data;
            end
        end
    end

    initial begin
        bus.in_valid         = '0;
        bus.in_data          = '0;
        bus.in_startofpacket = '0;
        bus.in_endofpacket   = '0;
        bus.out_ready        = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_data", 32'(bus.out_data), 32'h00);
        check_val("rst_out_channel", 32'(bus.out_channel), 32'd0);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drain(2);

        mon_r1 = 1'b1;
        send_pkt(0, 32'h0000_4241, 2, w0);
        drain(4);
        mon_r1 = 1'b0;
        exp_q = '{8'h7C, 8'h00, 8'h41, 8'h42};
        check_stream("t1");
        check_val("t1_wait", 32'(w0), 32'd2);
        check_val("t1_channel", 32'(bus.out_channel), 32'd0);
        check_val("t1_no_ready1", 32'(saw_r1), 32'd0);

        send_pkt(0, 32'h0000_0043, 1, w0);
        drain(4);
        exp_q = '{8'h43};
        check_stream("t2");
        check_val("t2_bubble", 32'(w0), 32'd1);

        fork
            send_pkt(1, 32'h0000_0061, 1, w1);
            send_pkt(0, 32'h0000_0060, 1, w0);
        join
        drain(4);
        exp_q = '{8'h7C, 8'h01, 8'h61, 8'h7C, 8'h00, 8'h60};
        check_stream("t3");
        check_val("t3_channel", 32'(bus.out_channel), 32'd0);

        send_pkt(1, 32'h0000_7D7C, 2, w1);
        drain(4);
        exp_q = '{8'h7C, 8'h01, 8'h7D, 8'h5C, 8'h7D, 8'h5D};
        check_stream("t4");
        check_val("t4_channel", 32'(bus.out_channel), 32'd1);

        ready_toggle = 1'b1;
        send_pkt(3, 32'h4433_2211, 4, w0);
        drain(12);
        ready_toggle  = 1'b0;
        bus.out_ready = 1'b1;
        drain(2);
        exp_q = '{8'h7C, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
        check_stream("t5");
        check_val("t5_channel", 32'(bus.out_channel), 32'd3);

        @(posedge clk);
        #1;
        bus.in_data[23:16]      = 8'hA0;
        bus.in_startofpacket[2] = 1'b1;
        bus.in_endofpacket[2]   = 1'b0;
        bus.in_valid[2]         = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset_n              = 1'b0;
        bus.in_valid         = '0;
        bus.in_startofpacket = '0;
        @(negedge clk);
        check_val("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        check_val("t6_rst_ready", 32'(bus.in_ready), 32'd0);
        check_val("t6_rst_channel", 32'(bus.out_channel), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cap_q.delete();
        send_pkt(2, 32'h0000_0055, 1, w0);
        drain(4);
        exp_q = '{8'h7C, 8'h02, 8'h55};
        check_stream("t6");
        check_val("t6_channel", 32'(bus.out_channel), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/peridot_phy_txarb.md
# peridot_phy_txarb

Round-robin arbiter that shares the single UART transmit byte path (Avalon-ST sink of the TX phy) between up to four byte-stream requesters. Each requester offers packets (SOP/EOP-framed bytes). The arbiter inserts a channel-select header whenever the transmitting channel changes, and escapes reserved byte values, so the far end can demultiplex the stream. It sits between host-side sources (JTAG bridge, debug console, etc.) and the UART TX phy. It is the transmit-side counterpart to the RX phy/demux path.

## Interface
- NUM_PORTS, 2: number of requester ports, legal 2..4.
- LOCK_PACKET, 1: 1 = grant held from first byte until EOP byte accepted; 0 = re-arbitrate after every byte.
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_PORTS  per-port byte valid.
- in_data  in  8*NUM_PORTS  per-port byte; port i at [8i+7:8i].
- in_startofpacket  in  NUM_PORTS  per-port SOP; informational only, not checked.
- in_endofpacket  in  NUM_PORTS  per-port EOP, qualified by in_valid.
- in_ready  out  NUM_PORTS  per-port ready, readyLatency 0.
- out_ready  in  1  TX phy ready.
- out_valid  out  1  byte valid to TX phy, registered.
- out_data  out  8  byte to TX phy, registered.
- out_channel  out  2  current channel register, registered, for status readback.

## Operation
- Reserved bytes: CH = 0x7C, ESC = 0x7D.
- Output slot is one register pair (out_valid, out_data). "Slot free" = !out_valid || out_ready.
- States:
  - IDLE
    - Wait for any in_valid and slot free.
    - Grant g = first requesting port searching from last_grant+1 upward, wrapping modulo NUM_PORTS.
    - If ch_valid==0 or g!=out_channel: load out_data=0x7C, out_valid=1, go CHNUM.
    - Else go DATA; no output load this cycle.
  - CHNUM
    - When slot free: load out_data={6'b0,g}, out_channel<=g, ch_valid<=1, go DATA.
  - DATA
    - in_ready[g] = slot free; all other in_ready = 0. in_ready is combinational from state, grant, out_valid and out_ready.
    - On handshake, byte b is 0x7C or 0x7D: load out_data=0x7D, esc_reg<=b^0x20, eop_pend<=in_endofpacket[g], go ESC.
    - On handshake, any other b: load out_data=b. Go IDLE if in_endofpacket[g] or LOCK_PACKET==0; else stay in DATA.
    - Requester dropping in_valid mid-packet: stay in DATA holding the grant, no timeout.
  - ESC
    - When slot free: load out_data=esc_reg.
    - Go IDLE if eop_pend or LOCK_PACKET==0; else go DATA.
- last_grant<=g on every transition out of DATA/ESC to IDLE.
- out_valid clears on out_ready when no new load occurs in the same cycle.
- Reset values: out_valid=0, out_data=0x00, out_channel=0, ch_valid=0, last_grant=NUM_PORTS-1 so port 0 wins first, state=IDLE, esc_reg=0, eop_pend=0. in_ready=0 during and after reset until DATA.
- Asserting reset_n low mid-packet aborts immediately. The partial byte is dropped. The next packet after reset always starts with a CH header, because ch_valid=0.

## Timing
- IDLE→CHNUM: header 0x7C visible on out_valid 1 cycle after the arbitration cycle.
- Channel-number byte: loaded in the first slot-free cycle in CHNUM.
- Data byte: appears on out_* the cycle after its in_valid&in_ready handshake.
- Same-channel packet: IDLE costs 1 bubble cycle before in_ready rises.
- Throughput with out_ready held at 1: 1 byte/cycle in DATA.
- Simultaneous out_ready and new load: out_valid stays 1 and out_data updates. No bubble and no duplicate byte.
- Simultaneous requests in IDLE: round-robin order strictly from last_grant+1; a port is never granted twice while another port is waiting.

## Test plan
- After reset, port0 sends packet {0x41 SOP, 0x42 EOP} with out_ready=1 → out stream 0x7C,0x00,0x41,0x42; out_channel=0; in_ready[1] is never 1.
- Port0 then sends {0x43 SOP/EOP} → out stream 0x43 only, no header; exactly one bubble cycle before in_ready[0] rises.
- Port0 and port1 both valid with single-byte packets, last_grant=0 → port1 first: 0x7C,0x01,b1, then 0x7C,0x00,b0.
- Port1 sends {0x7C, 0x7D EOP} → 0x7D,0x5C,0x7D,0x5D (after header); state returns to IDLE only after 0x5D.
- out_ready toggled 1010… during a 4-byte packet → every byte appears exactly once, in order, with out_data stable while out_valid=1 && out_ready=0.
- reset_n pulsed low mid-packet on port2, then port2 resends {0x55 EOP} → out_valid=0 during reset; afterwards 0x7C,0x02,0x55.
